cu_seq: RTL and testbench
=========================

CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 Parameter NUM_REGS, default 16, meaning width of the block-transfer register list (power of two, 2..32).
REQ-002 Parameter IDX_W, default $clog2(NUM_REGS), meaning the register index width.
REQ-003 Parameter OFF_W, default IDX_W+2, meaning the byte offset width (offset = 4 x transfer number).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr_valid  in  1  a decoded instruction is presented this cycle.
REQ-007 opcode  in  4  data-processing opcode.
REQ-008 mode  in  2  instruction class: 00 data-proc, 01 load/store, 10 branch, 11 block transfer.
REQ-009 s  in  1  S bit; in modes 01 and 11 it is the load bit (1 = load).
REQ-010 reg_list  in  NUM_REGS  block-transfer register mask.
REQ-011 stall  in  1  downstream hazard; freezes the block.
REQ-012 flush  in  1  discard the current instruction and the in-flight sequence.
REQ-013 wb_en, mem_r_en, mem_w_en, b, s_out  out  1 each  registered control bits.
REQ-014 exe_cmd  out  4  registered ALU command.
REQ-015 uop_valid  out  1  the outputs carry a valid micro-op.
REQ-016 uop_reg  out  IDX_W  register index for the current block-transfer micro-op, else 0.
REQ-017 uop_off  out  OFF_W  byte offset for the current block-transfer micro-op, else 0.
REQ-018 busy  out  1  sequencer in XFER; upstream holds its instruction and does not assert a new one.

Function
REQ-019 All outputs registered; latency from accepted instruction to outputs = 1 cycle.
REQ-020 Instruction accepted when state=IDLE, instr_valid=1 and stall=0; in any other cycle instr_valid is ignored.
REQ-021 Cycle with no accept and no XFER step: all outputs drive 0 (bubble).
REQ-022 Mode 00 (opcode -> exe_cmd, wb_en): 1101->0001,1; 1111->1001,1; 0100->0010,1; 0101->0011,1; 0010->0100,1; 0110->0101,1; 0000->0110,1; 1100->0111,1; 0001->1000,1; 1010->0100,0; 1000->0110,0; s_out=s; uop_valid=1.
REQ-023 Mode 00, opcode not listed: exe_cmd=0, wb_en=0, s_out=s, uop_valid=1.
REQ-024 Mode 01: exe_cmd=0010; s=1 gives wb_en=1, mem_r_en=1, s_out=0; s=0 gives mem_w_en=1, s_out=0.
REQ-025 Mode 10: b=1, all other control bits 0.
REQ-026 Mode 11 with reg_list!=0: move to XFER; emit one micro-op per set bit, lowest index first, one per unstalled cycle.
REQ-027 Each mode-11 micro-op: exe_cmd=0010, uop_reg=bit index, uop_off=4*k (k=0 for the first), s_out=0.
REQ-028 Each mode-11 micro-op for a load: wb_en=1, mem_r_en=1; for a store: mem_w_en=1.
REQ-029 The mask is latched at accept; set bits are cleared as they are issued.
REQ-030 State returns to IDLE in the same cycle the last micro-op is registered; a new instruction can be accepted in the next cycle.
REQ-031 busy=1 exactly while state=XFER with bits remaining after the current issue.
REQ-032 Mode 11 with reg_list=0: single bubble, uop_valid=0, state stays IDLE.
REQ-033 stall=1: all outputs, state, mask and offset hold their values.
REQ-034 flush=1 (overrides stall): outputs clear to 0, mask clears, state goes to IDLE; an instruction presented in that cycle is not accepted.
REQ-035 NUM_REGS set bits gives NUM_REGS micro-ops; uop_off reaches 4*(NUM_REGS-1) with no wrap.

Reset
REQ-036 rst=1 (overrides flush and stall): all outputs 0, state IDLE, mask 0, offset 0, from the next edge.
REQ-037 rst asserted mid-XFER abandons the sequence; no further micro-ops issue after release.

Verification
REQ-038 mode=00, opcode=0100, s=1, valid -> next cycle exe_cmd=0010, wb_en=1, s_out=1, uop_valid=1; then a bubble when valid=0.
REQ-039 mode=01, s=1 -> wb_en=1, mem_r_en=1, exe_cmd=0010, s_out=0; mode=01, s=0 -> mem_w_en=1 only; mode=10 -> b=1 only.
REQ-040 mode=11, s=1, reg_list=0x0025 -> three cycles with uop_reg 0,2,5, uop_off 0,4,8, wb_en=mem_r_en=1; busy=1 for the first two; new instruction accepted on cycle 4.
REQ-041 Same LDM with stall=1 for 2 cycles after the first micro-op -> outputs frozen at reg 0/off 0, then reg 2/off 4 and reg 5/off 8 resume.
REQ-042 flush asserted during the second micro-op of a 0x00F0 STM -> next cycle all outputs 0, busy=0, no remaining micro-ops; also mode=11 with reg_list=0 -> uop_valid=0, busy=0.
REQ-043 reg_list=all ones -> NUM_REGS micro-ops, last uop_off=4*(NUM_REGS-1); rst mid-sequence -> outputs 0 the next cycle.

Source files
------------

// File: rtl/cu_seq.sv
// -----------------------------------------------------------------------------
// cu_seq -- control-unit sequencer.
//
// Decodes one instruction per accepted cycle into registered control bits.
// Data-processing, load/store and branch instructions produce a single
// micro-op one cycle after acceptance. Block transfers (mode 11) expand the
// register mask into one micro-op per set bit, lowest index first, each
// carrying its register index and a byte offset of 4 x transfer number.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (wins over flush and stall)
//   instr_valid  decoded instruction presented this cycle
//   opcode[3:0]  data-processing opcode
//   mode[1:0]    00 data-proc, 01 load/store, 10 branch, 11 block transfer
//   s            S bit; load bit in modes 01 and 11
//   reg_list     block-transfer register mask
//   stall        freeze all state and outputs
//   flush        clear outputs and abandon any in-flight sequence
//   wb_en, mem_r_en, mem_w_en, b, s_out, exe_cmd[3:0]  registered control
//   uop_valid    outputs carry a valid micro-op
//   uop_reg      register index of the current block-transfer micro-op
//   uop_off      byte offset of the current block-transfer micro-op
//   busy         sequencer still has block-transfer micro-ops to issue
// -----------------------------------------------------------------------------
module cu_seq #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int OFF_W    = IDX_W + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [3:0]          opcode,
  input  logic [1:0]          mode,
  input  logic                s,
  input  logic [NUM_REGS-1:0] reg_list,
  input  logic                stall,
  input  logic                flush,
  output logic                wb_en,
  output logic                mem_r_en,
  output logic                mem_w_en,
  output logic                b,
  output logic                s_out,
  output logic [3:0]          exe_cmd,
  output logic                uop_valid,
  output logic [IDX_W-1:0]    uop_reg,
  output logic [OFF_W-1:0]    uop_off,
  output logic                busy
);

  typedef enum logic {IDLE, XFER} state_t;

  typedef struct packed {
    logic             wb_en;
    logic             mem_r_en;
    logic             mem_w_en;
    logic             b;
    logic             s_out;
    logic [3:0]       exe_cmd;
    logic             uop_valid;
    logic [IDX_W-1:0] uop_reg;
    logic [OFF_W-1:0] uop_off;
    logic             busy;
  } uop_t;

  localparam logic [3:0] CMD_ADD = 4'b0010;

  // Data-processing decode: returns {wb_en, exe_cmd}. Unlisted opcodes
  // decode to a no-op that still flows down the pipe.
  function automatic logic [4:0] dp_decode(input logic [3:0] op);
    case (op)
      4'b1101: return {1'b1, 4'b0001};
      4'b1111: return {1'b1, 4'b1001};
      4'b0100: return {1'b1, 4'b0010};
      4'b0101: return {1'b1, 4'b0011};
      4'b0010: return {1'b1, 4'b0100};
      4'b0110: return {1'b1, 4'b0101};
      4'b0000: return {1'b1, 4'b0110};
      4'b1100: return {1'b1, 4'b0111};
      4'b0001: return {1'b1, 4'b1000};
      4'b1010: return {1'b0, 4'b0100};
      4'b1000: return {1'b0, 4'b0110};
      default: return 5'b0;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [NUM_REGS-1:0] mask_q, mask_d;   // bits still to be issued
  logic [IDX_W-1:0]    cnt_q, cnt_d;     // transfers issued so far
  logic                load_q, load_d;
  uop_t                out_q, out_d;

  // Source of the micro-op issued this cycle: the latched sequence while in
  // XFER, or the incoming instruction on a block-transfer accept.
  logic                issue;
  logic [NUM_REGS-1:0] src_mask;
  logic [IDX_W-1:0]    src_cnt;
  logic                src_load;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_REGS-1:0] rest_mask;
  logic [4:0]          dp;

  // NOTE: every signal written here gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    load_d   = load_q;
    out_d    = out_q;
    issue    = 1'b0;
    src_mask = mask_q;
    src_cnt  = cnt_q;
    src_load = load_q;
    pick_idx = '0;
    dp       = dp_decode(opcode);

    if (!flush && !stall) begin
      if (state_q == XFER) begin
        issue = 1'b1;
      end else if (instr_valid && mode == 2'b11 && reg_list != '0) begin
        issue    = 1'b1;
        src_mask = reg_list;
        src_cnt  = '0;
        src_load = s;
      end
    end

    // Lowest set bit wins: scan downward so the last hit is the smallest.
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (src_mask[i]) pick_idx = IDX_W'(i);
    end
    // x & (x-1) clears exactly the lowest set bit.
    rest_mask = src_mask & (src_mask - NUM_REGS'(1));

    if (flush) begin
      out_d   = '0;
      mask_d  = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (!stall) begin
      out_d = '0;
      if (issue) begin
        out_d.uop_valid = 1'b1;
        out_d.exe_cmd   = CMD_ADD;
        out_d.wb_en     = src_load;
        out_d.mem_r_en  = src_load;
        out_d.mem_w_en  = ~src_load;
        out_d.uop_reg   = pick_idx;
        out_d.uop_off   = OFF_W'({src_cnt, 2'b00});
        mask_d          = rest_mask;
        cnt_d           = IDX_W'(src_cnt + 1'b1);
        load_d          = src_load;
        state_d         = (rest_mask != '0) ? XFER : IDLE;
      end else if (state_q == IDLE && instr_valid) begin
        case (mode)
          2'b00: begin
            out_d.uop_valid = 1'b1;
            out_d.wb_en     = dp[4];
            out_d.exe_cmd   = dp[3:0];
            out_d.s_out     = s;
          end
          2'b01: begin
            out_d.uop_valid = 1'b1;
            out_d.exe_cmd   = CMD_ADD;
            out_d.wb_en     = s;
            out_d.mem_r_en  = s;
            out_d.mem_w_en  = ~s;
          end
          2'b10: begin
            out_d.uop_valid = 1'b1;
            out_d.b         = 1'b1;
          end
          default: ;  // empty block transfer: bubble
        endcase
      end
      out_d.busy = (state_d == XFER);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      out_q   <= out_d;
    end
  end

  assign wb_en     = out_q.wb_en;
  assign mem_r_en  = out_q.mem_r_en;
  assign mem_w_en  = out_q.mem_w_en;
  assign b         = out_q.b;
  assign s_out     = out_q.s_out;
  assign exe_cmd   = out_q.exe_cmd;
  assign uop_valid = out_q.uop_valid;
  assign uop_reg   = out_q.uop_reg;
  assign uop_off   = out_q.uop_off;
  assign busy      = out_q.busy;

endmodule

// File: tb/tb_cu_seq.sv
// -----------------------------------------------------------------------------
// tb_cu_seq -- directed self-checking bench for cu_seq (NUM_REGS = 16).
// Outputs are packed into one word {busy, uop_valid, wb_en, mem_r_en,
// mem_w_en, b, s_out, exe_cmd, uop_reg, uop_off} and compared against
// hand-computed words built with mk().
// -----------------------------------------------------------------------------
module tb_cu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [1:0]  mode;
  logic        s;
  logic [15:0] reg_list;
  logic        stall;
  logic        flush;
  logic        wb_en, mem_r_en, mem_w_en, b, s_out;
  logic [3:0]  exe_cmd;
  logic        uop_valid;
  logic [3:0]  uop_reg;
  logic [5:0]  uop_off;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  cu_seq #(.NUM_REGS(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .mode(mode), .s(s), .reg_list(reg_list), .stall(stall), .flush(flush),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b),
    .s_out(s_out), .exe_cmd(exe_cmd), .uop_valid(uop_valid),
    .uop_reg(uop_reg), .uop_off(uop_off), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic bsy, input logic vld,
      input logic wb, input logic mr, input logic mw, input logic br,
      input logic so, input logic [3:0] cmd, input logic [3:0] rg,
      input logic [5:0] off);
    return {11'b0, bsy, vld, wb, mr, mw, br, so, cmd, rg, off};
  endfunction

  function automatic logic [31:0] obs();
    return {11'b0, busy, uop_valid, wb_en, mem_r_en, mem_w_en, b, s_out,
            exe_cmd, uop_reg, uop_off};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_valid = 0; opcode = 0; mode = 0; s = 0; reg_list = 0;
    stall = 0; flush = 0;
  endtask

  task automatic present(input logic [1:0] m, input logic [3:0] op,
                         input logic sb, input logic [15:0] rl);
    instr_valid = 1; mode = m; opcode = op; s = sb; reg_list = rl;
  endtask

  localparam logic [3:0] ADD = 4'b0010;

  // Data-processing vectors: opcode, s, expected exe_cmd, expected wb_en.
  typedef struct {
    logic [3:0] op;
    logic       sb;
    logic [3:0] cmd;
    logic       wb;
  } dp_vec_t;
  dp_vec_t dp_tab[6];

  initial begin
    dp_tab[0] = '{4'b1101, 1'b0, 4'b0001, 1'b1};
    dp_tab[1] = '{4'b1111, 1'b1, 4'b1001, 1'b1};
    dp_tab[2] = '{4'b1010, 1'b1, 4'b0100, 1'b0};
    dp_tab[3] = '{4'b1000, 1'b0, 4'b0110, 1'b0};
    dp_tab[4] = '{4'b0001, 1'b0, 4'b1000, 1'b1};
    dp_tab[5] = '{4'b0011, 1'b1, 4'b0000, 1'b0};  // unlisted opcode

    idle_inputs();
    rst = 1;
    step();
    check("reset", obs(), 32'h0);
    step();
    rst = 0;

    // Data-processing example, then a bubble.
    present(2'b00, 4'b0100, 1'b1, 16'h0);
    step();
    check("dp_add", obs(), mk(0,1,1,0,0,0,1,ADD,0,0));
    idle_inputs();
    step();
    check("bubble", obs(), 32'h0);

    foreach (dp_tab[i]) begin
      present(2'b00, dp_tab[i].op, dp_tab[i].sb, 16'h0);
      step();
      check($sformatf("dp_op%0d", i), obs(),
            mk(0,1,dp_tab[i].wb,0,0,0,dp_tab[i].sb,dp_tab[i].cmd,0,0));
    end

    // Load, store, branch.
    present(2'b01, 4'b0000, 1'b1, 16'h0);
    step();
    check("ldr", obs(), mk(0,1,1,1,0,0,0,ADD,0,0));
    present(2'b01, 4'b1111, 1'b0, 16'h0);
    step();
    check("str", obs(), mk(0,1,0,0,1,0,0,ADD,0,0));
    present(2'b10, 4'b0100, 1'b1, 16'hFFFF);
    step();
    check("branch", obs(), mk(0,1,0,0,0,1,0,4'b0000,0,0));

    // Stall in IDLE: outputs hold the branch, the new instruction is ignored.
    present(2'b00, 4'b1101, 1'b1, 16'h0);
    stall = 1;
    step();
    check("idle_stall", obs(), mk(0,1,0,0,0,1,0,4'b0000,0,0));
    stall = 0;
    idle_inputs();
    step();

    // LDM 0x0025; upstream keeps a branch presented while busy.
    present(2'b11, 4'b0000, 1'b1, 16'h0025);
    step();
    check("ldm_u0", obs(), mk(1,1,1,1,0,0,0,ADD,0,0));
    present(2'b10, 4'b0000, 1'b0, 16'h0);
    step();
    check("ldm_u1", obs(), mk(1,1,1,1,0,0,0,ADD,2,4));
    step();
    check("ldm_u2", obs(), mk(0,1,1,1,0,0,0,ADD,5,8));
    step();
    check("ldm_next", obs(), mk(0,1,0,0,0,1,0,4'b0000,0,0));
    idle_inputs();
    step();

    // Same LDM with a two-cycle stall after the first micro-op.
    present(2'b11, 4'b0000, 1'b1, 16'h0025);
    step();
    idle_inputs();
    check("stl_u0", obs(), mk(1,1,1,1,0,0,0,ADD,0,0));
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("stl_hold%0d", i), obs(), mk(1,1,1,1,0,0,0,ADD,0,0));
    end
    stall = 0;
    step();
    check("stl_u1", obs(), mk(1,1,1,1,0,0,0,ADD,2,4));
    step();
    check("stl_u2", obs(), mk(0,1,1,1,0,0,0,ADD,5,8));
    step();
    check("stl_end", obs(), 32'h0);

    // STM 0x00F0, flushed during the second micro-op.
    present(2'b11, 4'b0000, 1'b0, 16'h00F0);
    step();
    idle_inputs();
    check("stm_u0", obs(), mk(1,1,0,0,1,0,0,ADD,4,0));
    step();
    check("stm_u1", obs(), mk(1,1,0,0,1,0,0,ADD,5,4));
    flush = 1;
    stall = 1;
    step();
    check("stm_flush", obs(), 32'h0);
    flush = 0;
    stall = 0;
    step();
    check("stm_drained", obs(), 32'h0);

    // Flush blocks acceptance of an instruction presented with it.
    present(2'b10, 4'b0000, 1'b0, 16'h0);
    flush = 1;
    step();
    check("flush_noacc", obs(), 32'h0);
    idle_inputs();

    // Empty block transfer: single bubble, no XFER.
    present(2'b11, 4'b0000, 1'b1, 16'h0);
    step();
    check("empty_ldm", obs(), 32'h0);
    idle_inputs();
    step();
    check("empty_after", obs(), 32'h0);

    // All sixteen registers: offsets run to 60 without wrapping.
    present(2'b11, 4'b0000, 1'b1, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      step();
      idle_inputs();
      check($sformatf("full_u%0d", i), obs(),
            mk(i < 15, 1,1,1,0,0,0,ADD, 4'(i), 6'(4 * i)));
    end
    step();
    check("full_end", obs(), 32'h0);

    // Reset mid-sequence abandons the transfer.
    present(2'b11, 4'b0000, 1'b0, 16'hFFFF);
    step();
    idle_inputs();
    step();
    check("rst_pre", obs(), mk(1,1,0,0,1,0,0,ADD,1,4));
    rst = 1;
    flush = 1;
    step();
    check("rst_mid", obs(), 32'h0);
    rst = 0;
    flush = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst_after%0d", i), obs(), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
